sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, cycles per 16-bit SRAM half-access (legal 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 1024, data-memory byte address mapped to SRAM word 0.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port mem_read_enable  in  1  32-bit load request from the MEM stage.
REQ-006 SHALL have port mem_write_enable  in  1  32-bit store request from the MEM stage.
REQ-007 SHALL have port address  in  32  byte address (ALU result).
REQ-008 SHALL have port write_data  in  32  store data (Rm value).
REQ-009 SHALL have port read_data  out  32  registered load result.
REQ-010 SHALL have port ready  out  1  high = access complete or no request; pipeline freezes when low.
REQ-011 SHALL have port sram_addr  out  18  SRAM halfword address.
REQ-012 SHALL have port sram_dq_out  out  16  SRAM write data.
REQ-013 SHALL have port sram_dq_oe  out  1  high = drive sram_dq_out onto the bus.
REQ-014 SHALL have port sram_dq_in  in  16  SRAM read data.
REQ-015 SHALL have port sram_we_n  out  1  active-low SRAM write strobe.

Function
REQ-016 SHALL implement states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-017 SHALL, in IDLE with mem_write_enable=1, latch address/write_data and go to WR_LO; otherwise with mem_read_enable=1, latch and go to RD_LO. Write has priority when both are high.
REQ-018 SHALL remain WAIT_CYCLES cycles in each LO/HI state, counted by a 4-bit counter cleared on every state entry; LO->HI, HI->DONE.
REQ-019 SHALL go DONE->IDLE unconditionally; a request still asserted during DONE SHALL NOT start a new access.
REQ-020 SHALL drive ready = (IDLE and no request) or DONE, combinationally. A request therefore holds ready low for exactly 2*WAIT_CYCLES+1 cycles.
REQ-021 SHALL form eff = latched_address - BASE_ADDR (32-bit wrap) and drive sram_addr = {eff[18:2], 0} in LO states and {eff[18:2], 1} in HI states; ignore eff[1:0]; drive 0 in IDLE/DONE.
REQ-022 SHALL drive sram_dq_out = write_data[15:0] in WR_LO and [31:16] in WR_HI, else 0; sram_dq_oe=1 only in WR states.
REQ-023 SHALL drive sram_we_n=0 in WR_LO/WR_HI except the final counter cycle of each, giving the SRAM a strobe release with data and address stable; otherwise 1.
REQ-024 SHALL capture sram_dq_in into read_data[15:0] on the last cycle of RD_LO and into [31:16] on the last cycle of RD_HI. read_data is valid in DONE and held until the next read overwrites it.
REQ-025 SHALL leave read_data unchanged on writes.
REQ-026 SHALL ignore mem_*_enable, address and write_data changes while not in IDLE (latched copies used).

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set state=IDLE, counter=0, latched address/data=0, read_data=0, regardless of current state, aborting any access.
REQ-028 SHALL present after reset: sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, ready=1 if no request.

Structure
REQ-029 SHALL place the state enum and default WAIT_CYCLES/BASE_ADDR constants in shared package sram_ctrl_pkg.
REQ-030 SHALL be a single module with no sub-module; counter and FSM inline.

Verification
REQ-031 Read, WAIT_CYCLES=2, address=1032; model returns 0xBEEF at sram_addr 4, 0xDEAD at 5 -> ready low 5 cycles, read_data=0xDEADBEEF in DONE, sram_we_n always 1.
REQ-032 Write 0x12345678 to 1036 -> sram_addr 6 with dq 0x5678 then 7 with 0x1234; sram_we_n low 1 cycle per half; read_data unchanged; ready high 1 cycle in DONE.
REQ-033 Read and write both high, address 1024, data 0xCAFEF00D -> write path taken, halves 0xF00D@0, 0xBEEF-free bus; no read capture.
REQ-034 Request held through DONE, then new read at 1040 the cycle after -> exactly two accesses, second at sram_addr 8/9.
REQ-035 rst pulsed in RD_HI -> next cycle IDLE, read_data=0, sram_we_n=1, ready=1 with no request.
REQ-036 WAIT_CYCLES=1 read -> ready low 3 cycles, correct 32-bit assembly.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default constants for the 32-bit-over-16-bit SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

endpackage

// File: rtl/sram_controller.sv
// Bridges 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two timed halfword accesses, stalling the pipeline through ready.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access; accept a request (write wins over read)
// RD_LO | read low halfword, capture on last wait cycle
// RD_HI | read high halfword, capture on last wait cycle
// WR_LO | drive low halfword, strobe released on last wait cycle
// WR_HI | drive high halfword, strobe released on last wait cycle
// DONE  | access complete, ready high for one cycle, back to IDLE
import sram_ctrl_pkg::*;

module sram_controller #(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_enable,
  input  logic        mem_write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        last_cnt;
  logic        req;
  logic [31:0] eff;
  logic        unused_eff;

  assign last_cnt = (cnt_q == LAST_CNT);
  assign req      = mem_read_enable | mem_write_enable;
  // Byte offset into SRAM; only the word index is used, halfword select comes from the state.
  assign eff        = addr_q - BASE_ADDR;
  assign unused_eff = ^{eff[31:19], eff[1:0]};
  assign read_data  = rdata_q;

  // State, wait counter and latched request/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, counter and capture logic; counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (mem_write_enable) begin
          addr_d  = address;
          wdata_d = write_data;
          state_d = WR_LO;
        end else if (mem_read_enable) begin
          addr_d  = address;
          wdata_d = write_data;
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        if (last_cnt) begin
          rdata_d[15:0] = sram_dq_in;
          state_d       = RD_HI;
          cnt_d         = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RD_HI: begin
        if (last_cnt) begin
          rdata_d[31:16] = sram_dq_in;
          state_d        = DONE;
          cnt_d          = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_LO: begin
        if (last_cnt) begin
          state_d = WR_HI;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR_HI: begin
        if (last_cnt) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // SRAM bus and handshake outputs decoded from the current state.
  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_q)
      IDLE:  ready = ~req;
      RD_LO: sram_addr = {eff[18:2], 1'b0};
      RD_HI: sram_addr = {eff[18:2], 1'b1};
      WR_LO: begin
        sram_addr   = {eff[18:2], 1'b0};
        sram_dq_out = wdata_q[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last_cnt;
      end
      WR_HI: begin
        sram_addr   = {eff[18:2], 1'b1};
        sram_dq_out = wdata_q[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = last_cnt;
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule
